mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
Round-robin arbiter that shares the 8-input, 32-bit select mux between up to 8 requesters, for example multi-cycle datapath units that need to drive a shared bus.
- Drives the mux 3-bit select and a bus-valid qualifier.
- Enforces a one-cycle turnaround between owners.
- Forcibly reclaims the bus from a requester that holds it for longer than a bounded number of cycles.
- Sits beside the mux in the multi-cycle CPU; the mux itself stays purely combinational.

Parameters:
N_REQ, 8, number of requesters; must equal 2**SEL_W.
SEL_W, 3, width of the mux select.
MAX_HOLD, 16, maximum cycles a grant may last; legal range 2..2**HOLD_W.
HOLD_W, 5, hold-counter width; must be at least clog2(MAX_HOLD)+1.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req  in  N_REQ  per-requester request level; held high until granted and served.
done  in  N_REQ  per-requester release pulse; only the current owner's bit is honoured.
grant  out  N_REQ  one-hot grant; all zero when no owner.
sel  out  SEL_W  mux select; equals the owner index while granted.
bus_valid  out  1  high while the mux output carries the owner's data.
timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (rst=1 at an edge, regardless of state):
  - Next cycle: grant=0, sel=0, bus_valid=0, timeout=0.
  - rr pointer ptr=0, hold counter=0, state=IDLE.
  - A grant in progress is dropped immediately; the owner is not notified beyond the grant falling.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, choose the first set bit searching from ptr upward, wrapping 7->0.
  - At the next edge: grant=onehot(winner), sel=winner, bus_valid=1, hold=0, state=GRANT.
  - Latency: req seen at edge t -> grant visible after edge t+1 (one cycle).
  - If req=0, stay in IDLE; sel holds its last value (no toggling); bus_valid=0.
- GRANT (owner o):
  - hold increments by 1 each cycle in GRANT.
  - Normal release: at an edge with done[o]=1 or req[o]=0.
  - Forced release: at an edge where hold==MAX_HOLD-1 and no normal release. A grant therefore lasts at most MAX_HOLD cycles; timeout=1 for exactly the next cycle.
  - On either release, at the next cycle: grant=0, bus_valid=0, sel unchanged, ptr=(o+1) mod N_REQ, state=IDLE.
  - The mandatory IDLE cycle is the bus turnaround. Back-to-back owners therefore see at least one cycle with bus_valid=0.
- Simultaneous events:
  - done[o] on the same edge as the hold limit counts as a normal release; no timeout pulse.
  - done bits of non-owners are ignored.
  - req changes of non-owners during GRANT have no effect until IDLE.
- Fairness: a requester that holds req continuously is granted within N_REQ-1 other grants.
- Invariants:
  - grant is zero or one-hot.
  - bus_valid == (grant!=0).
  - sel == index(grant) whenever bus_valid=1.
- All outputs are registered; there is no combinational path from req or done to any output.

Decomposition:
- Shared package arb_pkg: state enum (IDLE, GRANT), N_REQ/SEL_W defaults, and a function for the wrapping priority search returning index plus found flag.
- One natural sub-module, rr_pick: combinational rotate-priority encoder (req, ptr -> idx, found). It is reused by any later arbiter.
- The top level holds the FSM, ptr, hold counter and output registers.
- The select mux is instantiated outside this block and fed from sel.

Test Plan:
1. Reset and single request: hold rst 2 cycles. Assert req=8'b0000_0100, done[2] 3 cycles later.
   -> 1 cycle after req: grant=8'b0000_0100, sel=2, bus_valid=1.
   -> After the done edge: grant=0, next search starts at 3.
2. Round-robin: req=8'hFF held, each owner pulses done after 1 cycle.
   -> sel sequence 0,1,2,...,7,0.
   -> One bus_valid=0 cycle between consecutive grants.
3. Timeout with MAX_HOLD=16: req[5]=1 held, no done.
   -> grant[5] high exactly 16 cycles, then timeout=1 for one cycle, grant=0.
   -> The next winner with req=8'h21 is index 0 (wrap from ptr=6).
4. done on the limit edge: req[3] held, done[3] asserted on the hold==15 edge.
   -> Release occurs, timeout stays 0.
5. Reset mid-grant: rst asserted while sel=6 and bus_valid=1.
   -> Next cycle: grant=0, sel=0, bus_valid=0, ptr=0.
   -> With req=8'h41 after reset, the first winner is index 0.
6. Non-owner noise: owner 1 granted; pulse done[4] and toggle req[7].
   -> No change to grant, sel or hold; owner 1 releases only on done[1].

Source files
------------

// File: rtl/mux_sel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared types and the wrapping priority search for the bus arbiter.
// Revision: 1.0
// ============================================================================
package arb_pkg;

    localparam int c_N_REQ = 8;
    localparam int c_SEL_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                found;
        logic [c_SEL_W-1:0]  idx;
    } pick_t;

    // First set bit at or above ptr, wrapping; a downward scan lets the
    // nearest candidate overwrite the farther ones.
    function automatic pick_t rr_search(input logic [c_N_REQ-1:0] req,
                                        input logic [c_SEL_W-1:0] ptr);
        pick_t              res;
        logic [c_SEL_W-1:0] cand;
        res = '0;
        for (int k = c_N_REQ - 1; k >= 0; k--) begin
            cand = ptr + c_SEL_W'(k);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/mux_sel_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotate-priority encoder (req, ptr -> idx, found).
// Revision: 1.0
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_found
);

    generate
        if (N_REQ == c_N_REQ && SEL_W == c_SEL_W) begin : g_pkg_search
            pick_t w_pick;
            assign w_pick  = rr_search(i_req, i_ptr);
            assign o_idx   = w_pick.idx;
            assign o_found = w_pick.found;
        end else begin : g_generic_search
            logic [SEL_W-1:0] w_cand;
            logic [SEL_W-1:0] w_idx;
            logic             w_found;
            // N_REQ == 2**SEL_W, so the SEL_W-bit add wraps for free.
            always_comb begin
                w_cand  = '0;
                w_idx   = '0;
                w_found = 1'b0;
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    w_cand = i_ptr + SEL_W'(k);
                    if (i_req[w_cand]) begin
                        w_found = 1'b1;
                        w_idx   = w_cand;
                    end
                end
            end
            assign o_idx   = w_idx;
            assign o_found = w_found;
        end
    endgenerate

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mux_sel_arbiter
// Brief   : Round-robin owner arbitration for the shared 8:1 select mux, with
//           a one-cycle turnaround and forced reclaim after MAX_HOLD cycles.
// Revision: 1.0
// ============================================================================
module mux_sel_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 8,
    parameter int SEL_W    = 3,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             bus_valid,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] c_HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        r_state_q,     w_state_d;
    logic [SEL_W-1:0]  r_ptr_q,       w_ptr_d;
    logic [HOLD_W-1:0] r_hold_q,      w_hold_d;
    logic [N_REQ-1:0]  r_grant_q,     w_grant_d;
    logic [SEL_W-1:0]  r_sel_q,       w_sel_d;
    logic              r_bus_valid_q, w_bus_valid_d;
    logic              r_timeout_q,   w_timeout_d;

    logic [SEL_W-1:0]  w_pick_idx;
    logic              w_pick_found;
    logic              w_rel_normal;
    logic              w_at_limit;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_ptr_q),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // The registered select doubles as the owner index while granted.
    assign w_rel_normal = done[r_sel_q] | ~req[r_sel_q];
    assign w_at_limit   = (r_hold_q == c_HOLD_LIMIT);

    always_comb begin
        w_state_d     = r_state_q;
        w_ptr_d       = r_ptr_q;
        w_hold_d      = r_hold_q;
        w_grant_d     = r_grant_q;
        w_sel_d       = r_sel_q;
        w_bus_valid_d = r_bus_valid_q;
        w_timeout_d   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                w_grant_d     = '0;
                w_bus_valid_d = 1'b0;
                if (w_pick_found) begin
                    w_state_d     = ST_GRANT;
                    w_grant_d     = N_REQ'(1) << w_pick_idx;
                    w_sel_d       = w_pick_idx;
                    w_bus_valid_d = 1'b1;
                    w_hold_d      = '0;
                end
            end
            ST_GRANT: begin
                if (w_rel_normal || w_at_limit) begin
                    w_state_d     = ST_IDLE;
                    w_grant_d     = '0;
                    w_bus_valid_d = 1'b0;
                    w_ptr_d       = r_sel_q + SEL_W'(1);
                    w_hold_d      = '0;
                    w_timeout_d   = ~w_rel_normal;
                end else begin
                    w_hold_d = r_hold_q + HOLD_W'(1);
                end
            end
            default: begin
                w_state_d     = ST_IDLE;
                w_grant_d     = '0;
                w_bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_ptr_q       <= '0;
            r_hold_q      <= '0;
            r_grant_q     <= '0;
            r_sel_q       <= '0;
            r_bus_valid_q <= 1'b0;
            r_timeout_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_hold_q      <= w_hold_d;
            r_grant_q     <= w_grant_d;
            r_sel_q       <= w_sel_d;
            r_bus_valid_q <= w_bus_valid_d;
            r_timeout_q   <= w_timeout_d;
        end
    end

    assign grant     = r_grant_q;
    assign sel       = r_sel_q;
    assign bus_valid = r_bus_valid_q;
    assign timeout   = r_timeout_q;

endmodule : mux_sel_arbiter
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_sel_arbiter
// Brief   : Self-checking bench: vector table, corner sequences, random run
//           against a behavioural owner/pointer model.
// Revision: 1.0
// ============================================================================
module tb_mux_sel_arbiter;

    localparam int c_MAX_HOLD = 16;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       bus_valid;
    logic       timeout;

    int checks;
    int failures;

    // Behavioural model: who owns the bus, how long, and where search resumes.
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_sel;
    bit m_to;

    mux_sel_arbiter #(
        .N_REQ    (8),
        .SEL_W    (3),
        .MAX_HOLD (c_MAX_HOLD),
        .HOLD_W   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .sel       (sel),
        .bus_valid (bus_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit normal;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_to = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_sel   = m_owner;
                    m_hold  = 0;
                end
            end
        end else begin
            m_to   = 0;
            normal = done[m_owner] || !req[m_owner];
            if (normal || m_hold == c_MAX_HOLD - 1) begin
                m_to    = !normal;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_grant"}, int'(grant), (m_owner < 0) ? 0 : (1 << m_owner));
        check({tag, "_sel"}, int'(sel), m_sel);
        check({tag, "_bus_valid"}, int'(bus_valid), (m_owner < 0) ? 0 : 1);
        check({tag, "_timeout"}, int'(timeout), int'(m_to));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = '0;
        step(); step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] done;
        logic [7:0] e_grant;
        logic [2:0] e_sel;
        logic       e_bv;
        logic       e_to;
    } vec_t;

    vec_t vecs[11];
    int   cnt;
    int   rr_exp;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; req = '0; done = '0;
        m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_to = 0;

        // Single request, release on done, search resumes above old owner.
        vecs[0]  = '{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h04, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h84, 8'h00, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h84, 8'h80, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst; req = vecs[i].req; done = vecs[i].done;
            step();
            check($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].e_grant));
            check($sformatf("vec%0d_sel", i), int'(sel), int'(vecs[i].e_sel));
            check($sformatf("vec%0d_bv", i), int'(bus_valid), int'(vecs[i].e_bv));
            check($sformatf("vec%0d_to", i), int'(timeout), int'(vecs[i].e_to));
        end

        // Round robin with all requesters active.
        do_reset();
        req = 8'hFF;
        step();
        for (int n = 0; n < 9; n++) begin
            rr_exp = n % 8;
            check("rr_seq_sel", int'(sel), rr_exp);
            check("rr_seq_bv", int'(bus_valid), 1);
            done = 8'h01 << sel;
            step();
            done = '0;
            check("rr_turnaround_bv", int'(bus_valid), 0);
            check_model("rr");
            step();
        end

        // Forced reclaim after MAX_HOLD cycles, then wrap from ptr=6.
        do_reset();
        req = 8'h20;
        step();
        cnt = 0;
        while (grant[5] && cnt < 40) begin
            cnt++;
            check_model("to_hold");
            step();
        end
        check("to_grant_cycles", cnt, c_MAX_HOLD);
        check("to_pulse", int'(timeout), 1);
        check("to_grant_zero", int'(grant), 0);
        req = 8'h21;
        step();
        check("to_pulse_width", int'(timeout), 0);
        check("to_wrap_sel", int'(sel), 0);
        check_model("to_wrap");

        // done on the hold-limit edge counts as a normal release.
        do_reset();
        req = 8'h08;
        step();
        for (int i = 0; i < 15; i++) step();
        check("lim_still_granted", int'(grant), 8'h08);
        done = 8'h08;
        step();
        done = '0;
        check("lim_no_timeout", int'(timeout), 0);
        check("lim_released", int'(grant), 0);
        check_model("lim");

        // Reset in the middle of a grant.
        do_reset();
        req = 8'h40;
        step();
        check("rmid_sel6", int'(sel), 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmid_grant", int'(grant), 0);
        check("rmid_sel", int'(sel), 0);
        check("rmid_bv", int'(bus_valid), 0);
        req = 8'h41;
        step();
        check("rmid_first_winner", int'(sel), 0);
        check_model("rmid");

        // Non-owner done and req noise must not disturb owner 1.
        do_reset();
        req = 8'h02;
        step();
        for (int i = 0; i < 4; i++) begin
            done = 8'h10;
            req  = (i % 2 == 0) ? 8'h82 : 8'h02;
            step();
            check("noise_grant", int'(grant), 8'h02);
            check_model("noise");
        end
        done = 8'h02;
        step();
        done = '0;
        check("noise_release", int'(grant), 0);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            rst  = ($urandom_range(0, 299) == 0);
            step();
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_sel_arbiter
`default_nettype wire
